// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: Tuse/Tnew operand hazards,
// multiply/divide busy window, and exception priority over every stall.
module hazard_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       D_rs,
   input  logic [4:0]       D_rt,
   input  logic [1:0]       D_tuse_rs,
   input  logic [1:0]       D_tuse_rt,
   input  logic             D_is_md,
   input  logic [4:0]       E_wa,
   input  logic [1:0]       E_tnew,
   input  logic [4:0]       M_wa,
   input  logic [1:0]       M_tnew,
   input  logic             E_md_start,
   input  logic             E_md_is_div,
   input  logic             req,
   output logic             pc_en,
   output logic             D_en,
   output logic             E_clr,
   output logic             flush,
   output logic             md_busy,
   output logic [1:0]       md_state,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int MD_W   = $clog2(MD_MAX + 1);
   localparam logic [MD_W-1:0] MULT_LOAD = MD_W'(MULT_CYC);
   localparam logic [MD_W-1:0] DIV_LOAD  = MD_W'(DIV_CYC);

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MULT = 2'd1,
      MD_DIV  = 2'd2
   } md_state_t;

   md_state_t        state_r, state_s;
   logic [MD_W-1:0]  md_cnt_r, md_cnt_s;
   logic             busy_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic             rs_hz_s, rt_hz_s, md_hz_s, stall_s;

   // Operand hazard detection and stall/flush output equations
   always_comb begin
      rs_hz_s = (D_rs != 5'd0) && (D_tuse_rs != 2'd3) &&
                (((D_rs == E_wa) && (E_tnew > D_tuse_rs)) ||
                 ((D_rs == M_wa) && (M_tnew > D_tuse_rs)));
      rt_hz_s = (D_rt != 5'd0) && (D_tuse_rt != 2'd3) &&
                (((D_rt == E_wa) && (E_tnew > D_tuse_rt)) ||
                 ((D_rt == M_wa) && (M_tnew > D_tuse_rt)));
      md_hz_s = D_is_md && (busy_r || E_md_start);
      stall_s = (rs_hz_s || rt_hz_s || md_hz_s) && !req;
   end

   assign pc_en     = !stall_s;
   assign D_en      = !stall_s;
   assign E_clr     = stall_s || req;
   assign flush     = req;
   assign md_busy   = busy_r;
   assign md_state  = state_r;
   assign stall_cnt = stall_cnt_r;

   // MD FSM next state; a start while busy is ignored, req only suppresses a new start
   always_comb begin
      state_s  = state_r;
      md_cnt_s = md_cnt_r;
      case (state_r)
         MD_IDLE: begin
            if (E_md_start && !req) begin
               if (E_md_is_div) begin
                  state_s  = MD_DIV;
                  md_cnt_s = DIV_LOAD;
               end else begin
                  state_s  = MD_MULT;
                  md_cnt_s = MULT_LOAD;
               end
            end else begin
               state_s  = MD_IDLE;
               md_cnt_s = '0;
            end
         end
         MD_MULT, MD_DIV: begin
            if (md_cnt_r == MD_W'(1)) begin
               state_s  = MD_IDLE;
               md_cnt_s = '0;
            end else begin
               md_cnt_s = md_cnt_r - MD_W'(1);
            end
         end
         default: begin
            state_s  = MD_IDLE;
            md_cnt_s = '0;
         end
      endcase
   end

   // State, countdown, busy flag and saturating stall statistics
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= MD_IDLE;
         md_cnt_r    <= '0;
         busy_r      <= 1'b0;
         stall_cnt_r <= '0;
      end else begin
         state_r  <= state_s;
         md_cnt_r <= md_cnt_s;
         busy_r   <= (state_s != MD_IDLE);
         if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second 4-bit-counter instance
// covers stall counter saturation.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  D_rs, D_rt, E_wa, M_wa;
   logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
   logic        D_is_md, E_md_start, E_md_is_div, req;
   logic        pc_en, D_en, E_clr, flush, md_busy;
   logic [1:0]  md_state;
   logic [31:0] stall_cnt;
   logic        s_pc_en, s_D_en, s_E_clr, s_flush, s_md_busy;
   logic [1:0]  s_md_state;
   logic [3:0]  s_stall_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
      .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
      .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
      .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .req(req),
      .pc_en(pc_en), .D_en(D_en), .E_clr(E_clr), .flush(flush),
      .md_busy(md_busy), .md_state(md_state), .stall_cnt(stall_cnt)
   );

   hazard_ctrl #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
      .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
      .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
      .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .req(req),
      .pc_en(s_pc_en), .D_en(s_D_en), .E_clr(s_E_clr), .flush(s_flush),
      .md_busy(s_md_busy), .md_state(s_md_state), .stall_cnt(s_stall_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
      D_is_md = 1'b0; E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd0; M_tnew = 2'd0;
      E_md_start = 1'b0; E_md_is_div = 1'b0; req = 1'b0;
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      #1;
   endtask

   task automatic check_ctrl(input string name, input logic exp_pc, input logic exp_clr,
                             input logic exp_flush);
      checks++;
      if (pc_en !== exp_pc || D_en !== exp_pc || E_clr !== exp_clr || flush !== exp_flush) begin
         errors++;
         $display("FAIL %s: pc_en=%b D_en=%b E_clr=%b flush=%b, expected pc_en=%b D_en=%b E_clr=%b flush=%b",
                  name, pc_en, D_en, E_clr, flush, exp_pc, exp_pc, exp_clr, exp_flush);
      end
   endtask

   task automatic check_md(input string name, input logic [1:0] exp_state, input logic exp_busy);
      checks++;
      if (md_state !== exp_state || md_busy !== exp_busy) begin
         errors++;
         $display("FAIL %s: md_state=%0d md_busy=%b, expected md_state=%0d md_busy=%b",
                  name, md_state, md_busy, exp_state, exp_busy);
      end
   endtask

   task automatic check_cnt(input string name, input logic [31:0] exp_cnt);
      checks++;
      if (stall_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL %s: stall_cnt=%0d, expected %0d", name, stall_cnt, exp_cnt);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      #3;
      check_md("reset_md", 2'd0, 1'b0);
      check_cnt("reset_cnt", 32'd0);
      check_ctrl("reset_ctrl", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check_md("after_reset_md", 2'd0, 1'b0);
      check_cnt("after_reset_cnt", 32'd0);
   endtask

   task automatic test_load_use();
      D_rs = 5'd5; D_tuse_rs = 2'd0; E_wa = 5'd5; E_tnew = 2'd2;
      #1;
      check_ctrl("load_use_ctrl", 1'b0, 1'b1, 1'b0);
      tick();
      check_cnt("load_use_cnt", 32'd1);
      idle_inputs();
      check_ctrl("load_use_clear", 1'b1, 1'b0, 1'b0);
      tick();
      check_cnt("load_use_cnt_hold", 32'd1);
   endtask

   task automatic test_forward();
      D_rs = 5'd5; D_tuse_rs = 2'd1; M_wa = 5'd5; M_tnew = 2'd1;
      #1;
      check_ctrl("fwd_m_ready", 1'b1, 1'b0, 1'b0);
      idle_inputs();
      D_rs = 5'd0; D_tuse_rs = 2'd0; E_wa = 5'd0; E_tnew = 2'd2;
      #1;
      check_ctrl("fwd_reg0", 1'b1, 1'b0, 1'b0);
      idle_inputs();
      D_rt = 5'd7; D_tuse_rt = 2'd1; M_wa = 5'd7; M_tnew = 2'd2;
      #1;
      check_ctrl("rt_m_hazard", 1'b0, 1'b1, 1'b0);
      D_tuse_rt = 2'd3;
      #1;
      check_ctrl("rt_unused", 1'b1, 1'b0, 1'b0);
      D_tuse_rt = 2'd1; E_wa = 5'd7; E_tnew = 2'd1; M_wa = 5'd0;
      #1;
      check_ctrl("rt_e_equal_tnew", 1'b1, 1'b0, 1'b0);
      idle_inputs();
   endtask

   task automatic test_div();
      pulse_reset();
      D_is_md = 1'b1; E_md_start = 1'b1; E_md_is_div = 1'b1;
      #1;
      check_ctrl("div_start_stall", 1'b0, 1'b1, 1'b0);
      tick();
      E_md_start = 1'b0; E_md_is_div = 1'b0;
      #1;
      for (int k = 1; k <= 10; k++) begin
         check_md($sformatf("div_busy_%0d", k), 2'd2, 1'b1);
         check_ctrl($sformatf("div_stall_%0d", k), 1'b0, 1'b1, 1'b0);
         tick();
      end
      check_md("div_done", 2'd0, 1'b0);
      check_cnt("div_cnt", 32'd11);
      check_ctrl("div_released", 1'b1, 1'b0, 1'b0);
      idle_inputs();
   endtask

   task automatic test_mult();
      pulse_reset();
      E_md_start = 1'b1; E_md_is_div = 1'b0;
      tick();
      E_md_start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         #1;
         check_md($sformatf("mult_busy_%0d", k), 2'd1, 1'b1);
         // an illegal restart while busy must not reload or retarget the unit
         E_md_start = (k == 2) ? 1'b1 : 1'b0;
         E_md_is_div = (k == 2) ? 1'b1 : 1'b0;
         tick();
      end
      E_md_start = 1'b0; E_md_is_div = 1'b0;
      #1;
      check_md("mult_done", 2'd0, 1'b0);
      check_cnt("mult_no_stall", 32'd0);
      idle_inputs();
   endtask

   task automatic test_exception();
      pulse_reset();
      D_rs = 5'd5; D_tuse_rs = 2'd0; E_wa = 5'd5; E_tnew = 2'd2; req = 1'b1;
      #1;
      check_ctrl("exc_over_hazard", 1'b1, 1'b1, 1'b1);
      tick();
      check_cnt("exc_cnt", 32'd0);
      idle_inputs();
      req = 1'b1; E_md_start = 1'b1; E_md_is_div = 1'b1;
      tick();
      check_md("exc_suppress_start", 2'd0, 1'b0);
      idle_inputs();
      E_md_start = 1'b1;
      tick();
      E_md_start = 1'b0; req = 1'b1;
      tick();
      check_md("exc_no_abort", 2'd1, 1'b1);
      idle_inputs();
      repeat (5) tick();
      check_md("exc_mult_done", 2'd0, 1'b0);
   endtask

   task automatic test_mid_reset();
      pulse_reset();
      D_is_md = 1'b1; E_md_start = 1'b1;
      tick();
      E_md_start = 1'b0;
      tick();
      check_cnt("pre_reset_cnt", 32'd2);
      reset = 1'b0;
      #1;
      check_md("mid_reset_md", 2'd0, 1'b0);
      check_cnt("mid_reset_cnt", 32'd0);
      idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      tick();
      check_md("post_reset_md", 2'd0, 1'b0);
   endtask

   task automatic test_saturation();
      pulse_reset();
      D_rs = 5'd9; D_tuse_rs = 2'd0; M_wa = 5'd9; M_tnew = 2'd1;
      repeat (20) tick();
      checks++;
      if (s_stall_cnt !== 4'd15) begin
         errors++;
         $display("FAIL sat_cnt: stall_cnt=%0d, expected 15", s_stall_cnt);
      end
      check_cnt("sat_wide_cnt", 32'd20);
      idle_inputs();
   endtask

   initial begin
      reset = 1'b0;
      test_reset();
      test_load_use();
      test_forward();
      test_div();
      test_mult();
      test_exception();
      test_mid_reset();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Stall/flush controller for the five-stage pipeline. It decides each cycle whether the PC and the F/D register advance, stall, or flush.
- Compares D-stage operand demand (Tuse) against E/M producer readiness (Tnew).
- Tracks the multiply/divide unit's busy window with an internal FSM and countdown.
- Gives exception requests priority over every stall.
- Drives PC enable, F/D enable, the D/E bubble and the stall statistics.

Parameters:
MULT_CYC, 5, busy cycles after a mult/multu start in E
DIV_CYC, 10, busy cycles after a div/divu start in E
CNT_W, 32, width of the stall statistics counter

Ports:
clk  in  1  pipeline clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
D_rs  in  5  rs field of the instruction in D
D_rt  in  5  rt field of the instruction in D
D_tuse_rs  in  2  cycles until rs is consumed (0/1/2); 3 = rs unused
D_tuse_rt  in  2  cycles until rt is consumed; 3 = rt unused
D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
E_wa  in  5  destination register of the E instruction (0 = none)
E_tnew  in  2  cycles until the E result is ready
M_wa  in  5  destination register of the M instruction
M_tnew  in  2  cycles until the M result is ready
E_md_start  in  1  E instruction launches a mult/div this cycle
E_md_is_div  in  1  qualifies E_md_start: 1 = div, 0 = mult
req  in  1  exception/interrupt request from CP0
pc_en  out  1  PC update enable
D_en  out  1  F/D register enable
E_clr  out  1  insert a bubble into the D/E register
flush  out  1  copy of req, fanned out to D/E/M/W registers
md_busy  out  1  multiply/divide unit busy
md_state  out  2  FSM state: 0 IDLE, 1 MULT, 2 DIV
stall_cnt  out  CNT_W  count of stall cycles, saturating

Behaviour:
- Reset (reset==0, async): md_state=IDLE, md count=0, md_busy=0, stall_cnt=0. Combinational outputs follow current inputs.
- Hazard term for rs:
  - (D_rs!=0) && (D_tuse_rs!=3), AND
  - either (D_rs==E_wa && E_tnew>D_tuse_rs) or (D_rs==M_wa && M_tnew>D_tuse_rs).
- Hazard term for rt: identical to rs with D_rt and D_tuse_rt.
- md_hz = D_is_md && (md_busy || E_md_start). The start cycle itself blocks.
- stall = (rs_hz || rt_hz || md_hz) && !req.
- Output equations:
  - pc_en = !stall
  - D_en = !stall
  - E_clr = stall || req
  - flush = req
- req priority: when req=1, stall=0, pc_en=1, D_en=1 and E_clr=1. F/D and PC take the handler path themselves.
- MD FSM transitions:
  - IDLE + E_md_start && !req → MULT (count=MULT_CYC) or DIV (count=DIV_CYC), selected by E_md_is_div.
  - MULT/DIV: count decrements each cycle; at count==1 the next state is IDLE with count=0.
  - E_md_start while not IDLE is illegal, since it is blocked by md_hz. It is ignored; no reload.
  - req does not abort an in-flight operation.
  - req in the same cycle as E_md_start suppresses the start.
- md_busy = (md_state!=IDLE), registered. The first busy cycle is the one after the start edge.
- Busy length is exactly MULT_CYC or DIV_CYC cycles.
- stall_cnt increments by 1 on each clock where stall=1 and saturates at all-ones.
- Register 0 never creates a hazard, even when E_wa==0 or M_wa==0 matches.
- Reset asserted mid-operation clears FSM, count and statistics immediately.
- After reset deassertion the first posedge operates normally.

Test Plan:
1. Load-use: D_rs=5, D_tuse_rs=0, E_wa=5, E_tnew=2 → pc_en=0, D_en=0, E_clr=1; stall_cnt 0→1 after one edge.
2. Forward covers it: D_rs=5, D_tuse_rs=1, M_wa=5, M_tnew=1 → no stall. Same with D_rs=0, E_wa=0, E_tnew=2 → no stall.
3. Div timing:
   - E_md_start=1, E_md_is_div=1 at edge t → md_state=2 and md_busy=1 for edges t+1..t+10, IDLE at t+11.
   - D_is_md=1 throughout → stall on the start cycle plus 10 cycles, so stall_cnt=11.
4. Exception during hazard: E-hazard active and req=1 → pc_en=1, D_en=1, E_clr=1, flush=1, stall_cnt unchanged.
   - req with E_md_start=1 → md_state stays IDLE.
5. Mid-mult reset: reset=0 two cycles after a mult start → md_busy=0, md_state=0, stall_cnt=0 without waiting for a clock edge.
6. Saturation: with CNT_W=4, hold the stall for 20 cycles → stall_cnt holds at 15.
